// File: rtl/wr_skid_frontend.sv
// wr_skid_frontend
//   Write-side ingress stage for the async FIFO, in the write clock domain.
//   A 2-entry skid buffer (head/tail) sits between a valid/ready upstream
//   stream and the write-pointer handler. s_ready comes only from the
//   buffer state and wrst, so wfull never reaches s_ready combinationally.
//
// Ports
//   wclk        write clock, rising edge
//   wrst        synchronous active-high reset
//   s_valid     upstream word valid
//   s_data      upstream word
//   s_ready     upstream may transfer this cycle
//   wdata       head word presented to FIFO memory
//   winc        write request to pointer handler / memory
//   wfull       registered full flag from the write-pointer handler
//   accept_cnt  saturating count of accepted words   (WR_FRONTEND_STATS_EN)
//   stall_cnt   saturating count of wfull-blocked cycles (WR_FRONTEND_STATS_EN)
//
// Configuration
//   WR_FRONTEND_STATS_EN : when defined, adds the two statistics counters
//                          and their ports. Default build leaves it undefined.

module wr_skid_frontend #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 32
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 s_valid,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 s_ready,
  output logic [DATA_SIZE-1:0] wdata,
  output logic                 winc,
  input  logic                 wfull
`ifdef WR_FRONTEND_STATS_EN
  ,
  output logic [CNT_SIZE-1:0]  accept_cnt,
  output logic [CNT_SIZE-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] head;
  logic [DATA_SIZE-1:0] tail;
  logic                 push;
  logic                 pop;

  // Output decodes. Forcing the outputs quiet while wrst is high keeps
  // stale buffer contents from leaking out during the reset cycle.
  assign s_ready = (state != TWO) & ~wrst;
  assign winc    = (state != EMPTY) & ~wfull & ~wrst;
  assign wdata   = wrst ? '0 : head;

  assign push = s_valid & s_ready;
  assign pop  = winc;

  // Skid buffer FSM. head always holds the oldest word; tail is only
  // occupied in TWO, and shifts into head when that word drains.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state <= ONE;
            head  <= s_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= s_data;
          end else if (push) begin
            state <= TWO;
            tail  <= s_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // s_ready is low here, so a pop is the only possible event.
          if (pop) begin
            state <= ONE;
            head  <= tail;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef WR_FRONTEND_STATS_EN
  // Statistics counters saturate at all-ones rather than wrapping.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      accept_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (push && (accept_cnt != '1)) begin
        accept_cnt <= accept_cnt + CNT_SIZE'(1);
      end
      if ((state != EMPTY) && wfull && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_SIZE'(1);
      end
    end
  end
`else
  // Counter width is only meaningful when statistics are enabled.
  logic [CNT_SIZE-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_wr_skid_frontend.sv
// tb_wr_skid_frontend
//   Self-checking bench for wr_skid_frontend. A queue-based reference model
//   (occupancy = queue size, head = front of queue) predicts s_ready, winc,
//   wdata and, with WR_FRONTEND_STATS_EN, the statistics counters. Directed
//   table vectors cover the documented scenarios; a long random run covers
//   ordering under arbitrary s_valid / wfull patterns.

module tb_wr_skid_frontend;

  localparam int DW = 8;
  localparam int CW = 32;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [DW-1:0] wdata;
  logic          winc;
  logic          wfull;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  longint        m_acc;
  longint        m_stall;
  longint        m_acc_sat;

`ifdef WR_FRONTEND_STATS_EN
  logic [CW-1:0] accept_cnt;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    sat_accept_cnt;
  logic [1:0]    sat_stall_cnt;
  logic          sat_s_ready;
  logic [DW-1:0] sat_wdata;
  logic          sat_winc;
`endif

  always #5 wclk = ~wclk;

  wr_skid_frontend #(.DATA_SIZE(DW), .CNT_SIZE(CW)) u_dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .wdata      (wdata),
    .winc       (winc),
    .wfull      (wfull)
`ifdef WR_FRONTEND_STATS_EN
    ,
    .accept_cnt (accept_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

`ifdef WR_FRONTEND_STATS_EN
  // Narrow-counter instance to exercise saturation.
  wr_skid_frontend #(.DATA_SIZE(DW), .CNT_SIZE(2)) u_dut_sat (
    .wclk       (wclk),
    .wrst       (wrst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (sat_s_ready),
    .wdata      (sat_wdata),
    .winc       (sat_winc),
    .wfull      (wfull),
    .accept_cnt (sat_accept_cnt),
    .stall_cnt  (sat_stall_cnt)
  );
`endif

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          f;
    logic          er;
    logic          ew;
    logic [DW-1:0] ed;
    logic          cd;
  } vec_t;

  vec_t tbl[17];

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelClear();
    mq.delete();
    m_acc     = 0;
    m_stall   = 0;
    m_acc_sat = 0;
  endtask

  // Hold reset for n cycles, checking the quiet outputs during reset.
  task automatic doReset(input int n);
    wrst    = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    wfull   = 1'b0;
    repeat (n) begin
      @(negedge wclk);
      checkOutput("rst_s_ready", s_ready, 0);
      checkOutput("rst_winc", winc, 0);
      checkOutput("rst_wdata", wdata, 0);
      @(posedge wclk);
    end
    #1;
    wrst    = 1'b0;
    s_valid = 1'b0;
    modelClear();
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle,
  // then advance the model at the clock edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic f,
                               output logic r_o, output logic w_o,
                               output logic [DW-1:0] d_o);
    logic exp_ready;
    logic exp_winc;
    logic wfull_changed;
    s_valid = v;
    s_data  = d;
    wfull_changed = (f !== wfull);
    wfull   = f;
    exp_ready = (mq.size() < 2);
    exp_winc  = (mq.size() > 0) && !f;
    if (wfull_changed) begin
      #1;
      checkOutput("s_ready_after_wfull_change", s_ready, exp_ready);
    end
    @(negedge wclk);
    r_o = s_ready;
    w_o = winc;
    d_o = wdata;
    checkOutput("s_ready", s_ready, exp_ready);
    checkOutput("winc", winc, exp_winc);
    if (mq.size() > 0) checkOutput("wdata", wdata, mq[0]);
`ifdef WR_FRONTEND_STATS_EN
    checkOutput("accept_cnt", accept_cnt, m_acc);
    checkOutput("stall_cnt", stall_cnt, m_stall);
    checkOutput("sat_accept_cnt", sat_accept_cnt, m_acc_sat);
`endif
    @(posedge wclk);
    if (v && exp_ready) begin
      m_acc++;
      if (m_acc_sat < 3) m_acc_sat++;
    end
    if ((mq.size() > 0) && f) m_stall++;
    if (exp_winc) void'(mq.pop_front());
    if (v && exp_ready) mq.push_back(d);
    #1;
  endtask

  initial begin
    logic          r;
    logic          w;
    logic [DW-1:0] dd;

    // Directed table: burst, full boundary, drain, push+pop in ONE
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 8'hA0, 1'b1};
    tbl[7]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 8'hA0, 1'b1};
    tbl[8]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 8'hA0, 1'b1};
    tbl[9]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1};
    tbl[10] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[13] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};

    s_data  = '0;
    s_valid = 1'b0;
    wfull   = 1'b0;
    modelClear();
    doReset(2);

    $display("[TB] directed table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].f, r, w, dd);
      checkOutput($sformatf("tbl%0d_s_ready", i), r, tbl[i].er);
      checkOutput($sformatf("tbl%0d_winc", i), w, tbl[i].ew);
      if (tbl[i].cd) checkOutput($sformatf("tbl%0d_wdata", i), dd, tbl[i].ed);
    end

    $display("[TB] reset while holding two words");
    applyStimulus(1'b1, 8'hC1, 1'b1, r, w, dd);
    applyStimulus(1'b1, 8'hC2, 1'b1, r, w, dd);
    checkOutput("two_s_ready_pre", s_ready, 0);
    doReset(1);
    applyStimulus(1'b0, 8'h00, 1'b0, r, w, dd);
    checkOutput("post_rst_s_ready", r, 1);
    checkOutput("post_rst_winc", w, 0);
    applyStimulus(1'b1, 8'hD1, 1'b0, r, w, dd);
    applyStimulus(1'b0, 8'h00, 1'b0, r, w, dd);
    checkOutput("post_rst_winc_d1", w, 1);
    checkOutput("post_rst_wdata_d1", dd, 8'hD1);

    $display("[TB] random run");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 3) == 0), r, w, dd);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, r, w, dd);
    checkOutput("drain_empty_winc", w, 0);

`ifdef WR_FRONTEND_STATS_EN
    $display("[TB] statistics counters");
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, r, w, dd);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, r, w, dd);
    @(negedge wclk);
    checkOutput("stats_accept_5", accept_cnt, 5);
    checkOutput("stats_stall_3", stall_cnt, 3);
    checkOutput("stats_sat_accept_3", sat_accept_cnt, 3);
    @(posedge wclk);
    #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
